// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Load/store port bundle between the core and the data responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ready;
    logic        ack;
    logic [15:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  ready, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, ack, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding data memory with programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    data_mem_responder_if.slave bus
);
    localparam int          c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT);
    localparam logic [15:0] c_DEPTH_W   = 16'(DEPTH);
    localparam bit          c_ZERO_WAIT = (WAIT == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_ack;
    logic        r_err;
    logic [15:0] r_mem [DEPTH];

    // With zero wait states the commit coincides with the accept, so the
    // request fields come straight from the bus instead of the latches.
    logic            w_from_bus;
    logic            w_c_we;
    logic [15:0]     w_c_addr;
    logic [15:0]     w_c_wdata;
    logic            w_enter_resp;
    logic            w_err;
    logic [c_AW-1:0] w_idx;

    assign w_from_bus   = (r_state == ST_IDLE);
    assign w_c_we       = w_from_bus ? bus.we    : r_we;
    assign w_c_addr     = w_from_bus ? bus.addr  : r_addr;
    assign w_c_wdata    = w_from_bus ? bus.wdata : r_wdata;
    assign w_enter_resp = ((r_state == ST_IDLE) && bus.req && c_ZERO_WAIT) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd1));
    assign w_err        = w_c_addr[0] | ({1'b0, w_c_addr[15:1]} >= c_DEPTH_W);
    assign w_idx        = w_c_addr[c_AW:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_rdata <= 16'h0000;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_cnt   <= c_WAIT_INIT;
                        r_state <= c_ZERO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_enter_resp) begin
                r_ack   <= 1'b1;
                r_err   <= w_err;
                r_rdata <= (w_err || w_c_we) ? 16'h0000 : r_mem[w_idx];
            end
        end
    end

    // Storage is deliberately not reset; gating on rst keeps a request held
    // during reset from writing the array.
    always_ff @(posedge clk) begin
        if (rst && w_enter_resp && w_c_we && !w_err) begin
            r_mem[w_idx] <= w_c_wdata;
        end
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.ack   = r_ack;
    assign bus.rdata = r_rdata;
    assign bus.err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Random and directed checks of data_mem_responder at WAIT=0/2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_v [2];
    logic        we_v;
    logic [15:0] addr_v;
    logic [15:0] wdata_v;

    data_mem_responder_if b0 ();
    data_mem_responder_if b2 ();

    assign b0.req   = req_v[0];
    assign b0.we    = we_v;
    assign b0.addr  = addr_v;
    assign b0.wdata = wdata_v;
    assign b2.req   = req_v[1];
    assign b2.we    = we_v;
    assign b2.addr  = addr_v;
    assign b2.wdata = wdata_v;

    data_mem_responder #(.DEPTH(256), .WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    data_mem_responder #(.DEPTH(256), .WAIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one word array per instance plus written flags.
    logic [15:0] mm [2][256];
    bit          mv [2][256];
    time         last_acc [2];
    int          prev_sel = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? b0.ready : b2.ready;
    endfunction
    function automatic logic ackv(input int sel);
        return (sel == 0) ? b0.ack : b2.ack;
    endfunction
    function automatic logic errv(input int sel);
        return (sel == 0) ? b0.err : b2.err;
    endfunction
    function automatic logic [15:0] rdv(input int sel);
        return (sel == 0) ? b0.rdata : b2.rdata;
    endfunction

    // Called at a negedge with the selected responder idle; returns at a
    // negedge with it idle again so calls can issue back to back.
    task automatic txn(input int sel, input logic w, input logic [15:0] a, input logic [15:0] d);
        int          wt;
        int          cyc;
        int          lows;
        bit          got;
        bit          e;
        bit          known;
        logic [15:0] exp_rd;
        wt = (sel == 0) ? 0 : 2;
        check("ready_before_req", rdy(sel), 1'b1);
        we_v = w; addr_v = a; wdata_v = d; req_v[sel] = 1'b1;
        @(posedge clk);
        if (prev_sel == sel)
            check("accept_spacing", 32'((($time - last_acc[sel]) / 10)), 32'(wt + 2));
        last_acc[sel] = $time;
        prev_sel = sel;

        e      = a[0] || (a[15:1] >= 15'd256);
        known  = 1'b1;
        exp_rd = 16'h0000;
        if (!e && w) begin
            mm[sel][a[8:1]] = d;
            mv[sel][a[8:1]] = 1'b1;
        end else if (!e) begin
            exp_rd = mm[sel][a[8:1]];
            known  = mv[sel][a[8:1]];
        end

        cyc = 0; lows = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (!rdy(sel)) lows++;
            if (ackv(sel)) begin
                got = 1'b1;
                req_v[sel] = 1'b0;
                // latency counted to the edge at which the initiator samples ack
                check("ack_latency", 32'(cyc + 1), 32'(wt + 1));
                check("ready_low_cycles", 32'(lows), 32'(wt + 1));
                check("err", errv(sel), e);
                if (known) check("rdata", rdv(sel), exp_rd);
            end else begin
                cyc++;
                req_v[sel] = 1'($urandom);
                we_v       = 1'($urandom);
                addr_v     = 16'($urandom);
                wdata_v    = 16'($urandom);
            end
        end
        if (!got) begin
            req_v[sel] = 1'b0;
            check("ack_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        check("no_extra_ack", ackv(sel), 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        int          sel;
        int          r;
        req_v[0] = 1'b0; req_v[1] = 1'b1;
        we_v = 1'b1; addr_v = 16'h0010; wdata_v = 16'hDEAD;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) mv[s][i] = 1'b0;

        // Request held high through reset must not be accepted.
        #3;
        check("rst_ready0", b0.ready, 1'b1);
        check("rst_ready2", b2.ready, 1'b1);
        check("rst_ack2",   b2.ack,   1'b0);
        check("rst_err2",   b2.err,   1'b0);
        check("rst_rdata2", b2.rdata, 16'h0000);
        @(negedge clk); @(negedge clk);
        check("rst_no_ack_held_req", b2.ack, 1'b0);
        req_v[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Abort a write while it is still waiting.
        txn(1, 1'b1, 16'h0010, 16'h1111);
        we_v = 1'b1; addr_v = 16'h0010; wdata_v = 16'h2222; req_v[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", b2.ready, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_ready", b2.ready, 1'b1);
        check("abort_ack",   b2.ack,   1'b0);
        @(negedge clk);
        check("abort_ack_during_rst", b2.ack, 1'b0);
        req_v[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_late_ack", b2.ack, 1'b0);
        prev_sel = -1;
        txn(1, 1'b0, 16'h0010, 16'h0000);

        // Directed cases.
        txn(1, 1'b1, 16'h0010, 16'hBEEF);
        txn(1, 1'b0, 16'h0010, 16'h0000);
        txn(0, 1'b1, 16'h0002, 16'h1234);
        txn(0, 1'b0, 16'h0002, 16'h0000);
        txn(1, 1'b1, 16'h0000, 16'h5A5A);
        txn(1, 1'b0, 16'h0003, 16'h0000);
        txn(1, 1'b1, 16'h0200, 16'hFFFF);
        txn(1, 1'b0, 16'h0000, 16'h0000);
        txn(1, 1'b1, 16'h01FE, 16'hA5A5);
        txn(1, 1'b0, 16'h01FE, 16'h0000);

        // Randomized traffic on both instances.
        for (int k = 0; k < 60; k++) begin
            sel = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            if (r == 0)      ra = 16'($urandom) | 16'h0001;
            else if (r == 1) ra = 16'($urandom_range(256, 32767) << 1);
            else if (r < 6)  ra = 16'($urandom_range(0, 15) << 1);
            else             ra = 16'($urandom_range(248, 255) << 1);
            txn(sel, 1'($urandom), ra, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
